// File: rtl/apb_slave_mem_if.sv
// APB2 bus bundle between the bridge (master) and the banked memory completer (slave).
interface apb_slave_mem_if;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB2 completer with four word-addressed banks, protocol-violation checking and
// transfer/error counters for scoreboard cross-checks.
module apb_slave_mem #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  Preset,
    apb_slave_mem_if.slave        bus,
    output logic                  proto_err,
    output logic [7:0]            err_count,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StExpAcc} state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [4][DEPTH];
    logic [31:0]     prdata_q;
    logic [3:0]      sel_q;
    logic [1:0]      bank_q;
    logic [IW-1:0]   idx_q;
    logic            write_q;

    logic [IW-1:0]   idx;
    logic [1:0]      bank;
    logic            sel_any;
    logic            sel_one;
    logic            match;
    logic            setup_ok;
    logic            commit;
    logic            err;

    assign idx     = bus.Paddr[IW+1:2];
    assign sel_any = |bus.Pselx;
    assign sel_one = sel_any && ((bus.Pselx & (bus.Pselx - 4'd1)) == 4'd0);
    assign match   = (bus.Pselx == sel_q) && (idx == idx_q) && (bus.Pwrite == write_q);
    assign bus.Prdata = prdata_q;

    always_comb begin
        bank = 2'd0;
        unique case (bus.Pselx)
            4'b0010: bank = 2'd1;
            4'b0100: bank = 2'd2;
            4'b1000: bank = 2'd3;
            default: bank = 2'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        setup_ok = 1'b0;
        commit   = 1'b0;
        err      = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel_any && !bus.Penable) begin
                    if (sel_one) begin
                        setup_ok = 1'b1;
                        state_d  = StExpAcc;
                    end else begin
                        err = 1'b1;
                    end
                end else if (sel_any) begin
                    err = 1'b1;
                end
            end
            StExpAcc: begin
                state_d = StIdle;
                if (!sel_any) begin
                    err = 1'b1;
                end else if (bus.Penable) begin
                    if (match) commit = 1'b1;
                    else       err    = 1'b1;
                end else begin
                    // A second setup is an error, but it still starts a fresh transfer.
                    err = 1'b1;
                    if (sel_one) begin
                        setup_ok = 1'b1;
                        state_d  = StExpAcc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Preset) begin
            state_q   <= StIdle;
            mem_q     <= '{default: '0};
            prdata_q  <= '0;
            sel_q     <= '0;
            bank_q    <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            proto_err <= 1'b0;
            err_count <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            state_q <= state_d;
            if (setup_ok) begin
                sel_q   <= bus.Pselx;
                bank_q  <= bank;
                idx_q   <= idx;
                write_q <= bus.Pwrite;
                // Read data is fetched at setup so it is stable for the whole access cycle.
                if (!bus.Pwrite) prdata_q <= mem_q[bank][idx];
            end
            if (commit) begin
                if (write_q) begin
                    mem_q[bank_q][idx_q] <= bus.Pwdata;
                    wr_count <= wr_count + 16'd1;
                end else begin
                    rd_count <= rd_count + 16'd1;
                end
            end
            if (err) begin
                proto_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed vector table, reset/saturation
// sequences, and randomized traffic against a transfer-level reference model.
module tb_apb_slave_mem;
    logic        clock = 1'b0;
    logic        Preset;
    logic        proto_err;
    logic [7:0]  err_count;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int total = 0;
    int bad   = 0;

    apb_slave_mem_if bus ();

    apb_slave_mem #(.DEPTH(16)) dut (
        .clock     (clock),
        .Preset    (Preset),
        .bus       (bus),
        .proto_err (proto_err),
        .err_count (err_count),
        .wr_count  (wr_count),
        .rd_count  (rd_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  sel;
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prd;
        int          errc;
        logic        perr;
        int          wrc;
        int          rdc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [3:0] sel, logic en, logic wr, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] prd, int errc, logic perr,
                                int wrc, int rdc);
        vec_t v;
        v.sel = sel; v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.prd = prd; v.errc = errc; v.perr = perr; v.wrc = wrc; v.rdc = rdc;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic [31:0] prd, int errc, logic perr,
                              int wrc, int rdc);
        chk({tag, " Prdata"},    bus.Prdata,         prd);
        chk({tag, " err_count"}, 32'(err_count),     32'(errc));
        chk({tag, " proto_err"}, 32'(proto_err),     32'(perr));
        chk({tag, " wr_count"},  32'(wr_count),      32'(wrc[15:0]));
        chk({tag, " rd_count"},  32'(rd_count),      32'(rdc[15:0]));
    endtask

    task automatic drive(logic rst, logic [3:0] sel, logic en, logic wr,
                         logic [31:0] addr, logic [31:0] wdata);
        Preset      = rst;
        bus.Pselx   = sel;
        bus.Penable = en;
        bus.Pwrite  = wr;
        bus.Paddr   = addr;
        bus.Pwdata  = wdata;
        @(posedge clock);
        #1;
    endtask

    // Reference model: a pending-transfer record plus plain arrays, following the rules.
    logic [31:0] m_mem [4][16];
    logic [31:0] m_prd;
    logic        m_pend;
    logic [3:0]  m_sel;
    int          m_idx;
    logic        m_wr;
    int          m_err;
    logic        m_perr;
    logic [15:0] m_wrc, m_rdc;

    function automatic int bank_of(logic [3:0] sel);
        int b = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) b = i;
        return b;
    endfunction

    function automatic void model_step(logic rst, logic [3:0] sel, logic en, logic wr,
                                       logic [31:0] addr, logic [31:0] wdata);
        int  idx = int'(addr[5:2]);
        bit  e   = 0;
        if (rst) begin
            for (int b = 0; b < 4; b++) for (int w = 0; w < 16; w++) m_mem[b][w] = '0;
            m_prd = '0; m_pend = 0; m_sel = '0; m_idx = 0; m_wr = 0;
            m_err = 0; m_perr = 0; m_wrc = '0; m_rdc = '0;
            return;
        end
        if (sel == 4'd0) begin
            if (m_pend) e = 1;
            m_pend = 0;
        end else if (en) begin
            if (m_pend && sel == m_sel && idx == m_idx && wr == m_wr) begin
                if (wr) begin
                    m_mem[bank_of(sel)][idx] = wdata;
                    m_wrc++;
                end else begin
                    m_rdc++;
                end
            end else begin
                e = 1;
            end
            m_pend = 0;
        end else begin
            if (m_pend) e = 1;
            m_pend = 0;
            if ($countones(sel) == 1) begin
                m_pend = 1; m_sel = sel; m_idx = idx; m_wr = wr;
                if (!wr) m_prd = m_mem[bank_of(sel)][idx];
            end else begin
                e = 1;
            end
        end
        if (e) begin
            m_perr = 1;
            if (m_err < 255) m_err++;
        end
    endfunction

    task automatic rstep(logic rst, logic [3:0] sel, logic en, logic wr,
                         logic [31:0] addr, logic [31:0] wdata);
        model_step(rst, sel, en, wr, addr, wdata);
        drive(rst, sel, en, wr, addr, wdata);
        check_outs("rand", m_prd, m_err, m_perr, int'(m_wrc), int'(m_rdc));
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] a;
        logic        w;
        int          k;

        // Reset state.
        drive(1, 4'd0, 0, 0, 32'd0, 32'd0);
        drive(1, 4'd0, 0, 0, 32'd0, 32'd0);
        check_outs("reset", 32'd0, 0, 0, 0, 0);

        // Write then read back bank 0 idx 3; setup-cycle wdata is a decoy.
        add(4'b0001, 0, 1, 32'h0C, 32'h21524110, 32'h0, 0, 0, 0, 0);
        add(4'b0001, 1, 1, 32'h0C, 32'hDEADBEEF, 32'h0, 0, 0, 1, 0);
        add(4'b0001, 0, 0, 32'h0C, 32'h0, 32'hDEADBEEF, 0, 0, 1, 0);
        add(4'b0001, 1, 0, 32'h0C, 32'h0, 32'hDEADBEEF, 0, 0, 1, 1);
        // Idx 5 in each bank, then read all four.
        for (int n = 0; n < 4; n++) begin
            add(4'(1 << n), 0, 1, 32'h14, 32'h0, 32'hDEADBEEF, 0, 0, 1 + n, 1);
            add(4'(1 << n), 1, 1, 32'h14, 32'h11111111 * (n + 1), 32'hDEADBEEF, 0, 0, 2 + n, 1);
        end
        for (int n = 0; n < 4; n++) begin
            add(4'(1 << n), 0, 0, 32'h14, 32'h0, 32'h11111111 * (n + 1), 0, 0, 5, 1 + n);
            add(4'(1 << n), 1, 0, 32'h14, 32'h0, 32'h11111111 * (n + 1), 0, 0, 5, 2 + n);
        end
        // Index aliasing and ignored low bits.
        add(4'b0001, 0, 1, 32'h44, 32'h0, 32'h44444444, 0, 0, 5, 5);
        add(4'b0001, 1, 1, 32'h44, 32'hA5A5A5A5, 32'h44444444, 0, 0, 6, 5);
        add(4'b0001, 0, 0, 32'h04, 32'h0, 32'hA5A5A5A5, 0, 0, 6, 5);
        add(4'b0001, 1, 0, 32'h04, 32'h0, 32'hA5A5A5A5, 0, 0, 6, 6);
        add(4'b0001, 0, 0, 32'h07, 32'h0, 32'hA5A5A5A5, 0, 0, 6, 6);
        add(4'b0001, 1, 0, 32'h07, 32'h0, 32'hA5A5A5A5, 0, 0, 6, 7);
        // Protocol violations.
        add(4'b0001, 1, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 1, 1, 6, 7);
        add(4'b0011, 0, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 2, 1, 6, 7);
        add(4'b0010, 0, 1, 32'h00, 32'hBAD, 32'hA5A5A5A5, 2, 1, 6, 7);
        add(4'b0010, 1, 1, 32'h04, 32'hBAD, 32'hA5A5A5A5, 3, 1, 6, 7);
        add(4'b0100, 0, 1, 32'h00, 32'hBAD, 32'hA5A5A5A5, 3, 1, 6, 7);
        add(4'b0000, 0, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 4, 1, 6, 7);
        // Nothing written by the violations.
        add(4'b0010, 0, 0, 32'h04, 32'h0, 32'h0, 4, 1, 6, 7);
        add(4'b0010, 1, 0, 32'h04, 32'h0, 32'h0, 4, 1, 6, 8);
        add(4'b0010, 0, 0, 32'h00, 32'h0, 32'h0, 4, 1, 6, 8);
        add(4'b0010, 1, 0, 32'h00, 32'h0, 32'h0, 4, 1, 6, 9);
        add(4'b0100, 0, 0, 32'h00, 32'h0, 32'h0, 4, 1, 6, 9);
        add(4'b0100, 1, 0, 32'h00, 32'h0, 32'h0, 4, 1, 6, 10);
        add(4'b0001, 0, 0, 32'h04, 32'h0, 32'hA5A5A5A5, 4, 1, 6, 10);
        add(4'b0001, 1, 0, 32'h04, 32'h0, 32'hA5A5A5A5, 4, 1, 6, 11);
        // Back-to-back write then read.
        add(4'b0001, 0, 1, 32'h08, 32'h0, 32'hA5A5A5A5, 4, 1, 6, 11);
        add(4'b0001, 1, 1, 32'h08, 32'h12345678, 32'hA5A5A5A5, 4, 1, 7, 11);
        add(4'b0001, 0, 0, 32'h08, 32'h0, 32'h12345678, 4, 1, 7, 11);
        add(4'b0001, 1, 0, 32'h08, 32'h0, 32'h12345678, 4, 1, 7, 12);

        drive(0, 4'd0, 0, 0, 32'd0, 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].sel, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check_outs($sformatf("vec%0d", i), vecs[i].prd, vecs[i].errc, vecs[i].perr,
                       vecs[i].wrc, vecs[i].rdc);
        end

        // Reset during the access cycle of a write aborts it and clears everything.
        drive(0, 4'b1000, 0, 1, 32'h00, 32'h0);
        drive(1, 4'b1000, 1, 1, 32'h00, 32'hFFFFFFFF);
        check_outs("rst_abort", 32'h0, 0, 0, 0, 0);
        drive(0, 4'b0001, 0, 0, 32'h08, 32'h0);
        drive(0, 4'b0001, 1, 0, 32'h08, 32'h0);
        check_outs("rst_mem_b0", 32'h0, 0, 0, 0, 1);
        drive(0, 4'b1000, 0, 0, 32'h00, 32'h0);
        drive(0, 4'b1000, 1, 0, 32'h00, 32'h0);
        check_outs("rst_mem_b3", 32'h0, 0, 0, 0, 2);

        // err_count saturation.
        for (int i = 1; i <= 256; i++) begin
            drive(0, 4'b0001, 1, 0, 32'h0, 32'h0);
            if (i == 254) chk("sat254", 32'(err_count), 32'd254);
        end
        chk("sat255", 32'(err_count), 32'd255);
        chk("sat_perr", 32'(proto_err), 32'd1);

        // Randomized traffic against the model.
        rstep(1, 4'd0, 0, 0, 32'd0, 32'd0);
        for (int t = 0; t < 400; t++) begin
            k = $urandom_range(0, 19);
            s = 4'(1 << $urandom_range(0, 3));
            a = $urandom;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (k < 14) begin
                rstep(0, s, 0, w, a, $urandom);
                if ($urandom_range(0, 7) == 0) a = a ^ 32'h4;
                rstep(0, s, 1, w, a, d);
            end else if (k < 19) begin
                rstep(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w, a, d);
            end else begin
                rstep(1, s, 1'($urandom_range(0, 1)), w, a, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
